// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and widths for the data-memory responder
package mem_pkg;
    localparam int WORD_W    = 16;
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - CPU-to-data-memory request/response bus
interface data_mem_responder_if;
    logic                       req_valid;
    logic                       req_wr;
    logic [15:0]                req_addr;
    logic [mem_pkg::WORD_W-1:0] req_wdata;
    logic                       req_ready;
    logic                       resp_valid;
    logic [mem_pkg::WORD_W-1:0] resp_rdata;
    logic                       busy;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy
    );
endinterface

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word storage, synchronous write, asynchronous read, no reset
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] widx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ridx,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];
endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency load/store responder with a one-cycle response pulse
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    data_mem_responder_if.slave bus
);
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be within 1..15");
    end

    localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(LATENCY - 1);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

    state_t                state, next_state;
    logic [LAT_CNT_W-1:0]  cnt, next_cnt;
    logic                  wr_q;
    logic [ADDR_W-1:0]     idx_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [WORD_W-1:0]     rdata_q;
    logic                  resp_valid_q;

    logic                  accept;
    logic                  cur_wr;
    logic [ADDR_W-1:0]     req_idx;
    logic [ADDR_W-1:0]     ridx;
    logic [WORD_W-1:0]     arr_rdata;
    logic                  we;
    logic                  unused_addr_bits;

    assign req_idx          = bus.req_addr[ADDR_W:1];
    assign unused_addr_bits = ^{bus.req_addr[15:ADDR_W+1], bus.req_addr[0]};
    assign accept           = bus.req_valid && (state == IDLE);

    // With LATENCY=1 the response cycle follows the accept edge directly, so the
    // read index and access type come straight from the bus rather than the latches.
    assign ridx   = (state == IDLE) ? req_idx : idx_q;
    assign cur_wr = (state == IDLE) ? bus.req_wr : wr_q;

    // Gating with rst_n keeps a reset that lands on the RESP cycle from committing.
    assign we = (state == RESP) && wr_q && rst_n;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_cnt   = CNT_INIT;
                    next_state = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt <= CNT_ONE) begin
                    next_state = RESP;
                end
                if (cnt != '0) begin
                    next_cnt = cnt - 1'b1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= next_cnt;
            resp_valid_q <= (next_state == RESP);
            if (accept) begin
                wr_q    <= bus.req_wr;
                idx_q   <= req_idx;
                wdata_q <= bus.req_wdata;
            end
            // Only one request is ever in flight, so nothing writes the array on the
            // edge entering RESP; capturing here equals the array at the start of RESP.
            if ((next_state == RESP) && !cur_wr) begin
                rdata_q <= arr_rdata;
            end
        end
    end

    mem_array #(.ADDR_W(ADDR_W)) u_mem_array (
        .clk   (clk),
        .we    (we),
        .widx  (idx_q),
        .wdata (wdata_q),
        .ridx  (ridx),
        .rdata (arr_rdata)
    );

    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for LATENCY=4 and LATENCY=1 responders
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int ADDR_W = 10;
    localparam int NW     = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n4, rst_n1;

    data_mem_responder_if bus4();
    data_mem_responder_if bus1();

    data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n4),
        .bus   (bus4.slave)
    );

    data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (bus1.slave)
    );

    typedef struct {
        int          due;
        bit          is_load;
        int          idx;
        logic [15:0] data;
        bit          known;
    } exp_t;

    exp_t        sb [2][$];
    logic [15:0] model [2][NW];
    bit          known [2][NW];
    logic [15:0] last_rdata [2];
    bit          last_known [2];
    int          lat [2] = '{4, 1};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_on   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? bus4.req_ready : bus1.req_ready;
    endfunction

    task automatic drive(input int d, input logic v, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (d == 0) begin
            bus4.req_valid = v; bus4.req_wr = wr; bus4.req_addr = addr; bus4.req_wdata = wdata;
        end else begin
            bus1.req_valid = v; bus1.req_wr = wr; bus1.req_addr = addr; bus1.req_wdata = wdata;
        end
    endtask

    // Called at negedge+1; the request is held until the responder is idle.
    task automatic send(input int d, input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
        exp_t e;
        bit   done = 1'b0;
        drive(d, 1'b1, wr, addr, wdata);
        for (int t = 0; t < 40 && !done; t++) begin
            if (rdy(d)) begin
                e.due     = cyc + lat[d];
                e.is_load = !wr;
                e.idx     = int'(addr[ADDR_W:1]);
                e.data    = wr ? wdata : model[d][e.idx];
                e.known   = wr || known[d][e.idx];
                sb[d].push_back(e);
                done = 1'b1;
            end
            @(negedge clk); #1;
        end
        drive(d, 1'b0, 1'b0, 16'h0, 16'h0);
        if (!done) flag($sformatf("accept_timeout[%0d]", d));
    endtask

    task automatic rand_run(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            automatic bit          wr = 1'($urandom_range(0, 1));
            automatic logic [15:0] a  = 16'(($urandom & 32'h0000_F800) | $urandom_range(0, 63));
            automatic logic [15:0] w  = 16'($urandom);
            send(d, wr, a, w);
        end
    endtask

    task automatic drain(input int d);
        for (int t = 0; t < 40 && sb[d].size() != 0; t++) @(negedge clk);
        if (sb[d].size() != 0) flag($sformatf("drain_timeout[%0d]", d));
    endtask

    task automatic monitor(input int d, input logic rv, input logic ready,
                           input logic bsy, input logic [15:0] rd);
        exp_t e;
        chk($sformatf("req_ready[%0d]", d), 32'(ready), 32'(sb[d].size() == 0));
        chk($sformatf("busy[%0d]", d), 32'(bsy), 32'(sb[d].size() != 0));
        if (rv) begin
            if (sb[d].size() == 0) begin
                flag($sformatf("unexpected_resp_valid[%0d]", d));
            end else begin
                e = sb[d].pop_front();
                chk($sformatf("resp_cycle[%0d]", d), 32'(cyc), 32'(e.due));
                if (e.is_load) begin
                    last_rdata[d] = e.data;
                    last_known[d] = e.known;
                end else begin
                    model[d][e.idx] = e.data;
                    known[d][e.idx] = 1'b1;
                end
            end
        end else if (sb[d].size() != 0 && sb[d][0].due < cyc) begin
            flag($sformatf("missed_resp_valid[%0d] due=%0d", d, sb[d][0].due));
            void'(sb[d].pop_front());
        end
        if (last_known[d]) chk($sformatf("resp_rdata[%0d]", d), 32'(rd), 32'(last_rdata[d]));
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            monitor(0, bus4.resp_valid, bus4.req_ready, bus4.busy, bus4.resp_rdata);
            monitor(1, bus1.resp_valid, bus1.req_ready, bus1.busy, bus1.resp_rdata);
        end
    end

    initial begin
        rst_n4 = 1'b0;
        rst_n1 = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int d = 0; d < 2; d++) begin
            last_rdata[d] = 16'h0;
            last_known[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n4 = 1'b1;
        rst_n1 = 1'b1;
        chk("reset_req_ready[0]", 32'(bus4.req_ready), 32'd1);
        chk("reset_resp_valid[0]", 32'(bus4.resp_valid), 32'd0);
        chk("reset_busy[0]", 32'(bus4.busy), 32'd0);
        chk("reset_resp_rdata[0]", 32'(bus4.resp_rdata), 32'd0);
        chk("reset_req_ready[1]", 32'(bus1.req_ready), 32'd1);
        chk("reset_resp_valid[1]", 32'(bus1.resp_valid), 32'd0);
        chk("reset_busy[1]", 32'(bus1.busy), 32'd0);
        chk("reset_resp_rdata[1]", 32'(bus1.resp_rdata), 32'd0);
        mon_on = 1'b1;
        #1;
        fork
            begin
                send(0, 1'b1, 16'h0010, 16'hBEEF);
                send(0, 1'b0, 16'h0010, 16'h0000);
                send(0, 1'b1, 16'h0030, 16'h1111);
                send(0, 1'b1, 16'h0030, 16'h2222);
                send(0, 1'b0, 16'h0030, 16'h0000);
                send(0, 1'b1, 16'h0002, 16'h1234);
                send(0, 1'b0, 16'(2 + (1 << (ADDR_W + 1))), 16'h0000);
                send(0, 1'b0, 16'h0003, 16'h0000);
                send(0, 1'b1, 16'h0020, 16'h5555);
                send(0, 1'b1, 16'h0020, 16'hAAAA);
                rst_n4 = 1'b0;
                sb[0].delete();
                last_rdata[0] = 16'h0;
                last_known[0] = 1'b1;
                @(negedge clk); #1;
                rst_n4 = 1'b1;
                send(0, 1'b0, 16'h0020, 16'h0000);
                rand_run(0, 40);
            end
            begin
                send(1, 1'b1, 16'h0010, 16'hC0DE);
                send(1, 1'b0, 16'h0010, 16'h0000);
                send(1, 1'b1, 16'h0012, 16'h0BAD);
                send(1, 1'b0, 16'h0013, 16'h0000);
                rand_run(1, 60);
            end
        join
        drain(0);
        drain(1);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
